// File: rtl/keypad_scan_debounce.sv
// Row/column matrix keypad scanner: finds a pressed key, debounces press and release,
// and hands one linear key code per press to the consumer through a valid/ready handshake.
module keypad_scan_debounce #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int CODE_W          = $clog2(ROWS*COLS)
) (
    input  logic              clk_div,
    input  logic              rst,
    input  logic [ROWS-1:0]   sync_row,
    output logic [COLS-1:0]   col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_held
);

    localparam int CIDX_W = $clog2(COLS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int CNT_W  = 4;
    localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CIDX_W-1:0] C_LAST   = CIDX_W'(COLS-1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SCAN = 3'd1,
        DEB  = 3'd2,
        EMIT = 3'd3,
        REL  = 3'd4
    } state_t;

    state_t             state_q,    state_d;
    logic [CIDX_W-1:0]  c_q,        c_d;
    logic [ROWS-1:0]    row_pat_q,  row_pat_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [CODE_W-1:0]  key_code_q, key_code_d;

    logic [CNT_W-1:0]   cnt_inc;
    logic [COLS-1:0]    col_onehot;
    logic [ROW_W-1:0]   low_row;
    logic [CODE_W-1:0]  deb_code;

    assign cnt_inc = cnt_q + CNT_W'(1);

    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_col_dec
            assign col_onehot[gi] = (c_q == CIDX_W'(gi));
        end
    endgenerate

    // Descending loop so the lowest set row index is the one left standing
    always_comb begin
        low_row = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (row_pat_q[r]) begin
                low_row = ROW_W'(r);
            end
        end
    end

    assign deb_code = CODE_W'(int'(low_row) * COLS + int'(c_q));

    always_ff @(posedge clk_div) begin
        if (rst) begin
            state_q    <= IDLE;
            c_q        <= '0;
            row_pat_q  <= '0;
            cnt_q      <= '0;
            key_code_q <= '0;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            row_pat_q  <= row_pat_d;
            cnt_q      <= cnt_d;
            key_code_q <= key_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        c_d        = c_q;
        row_pat_d  = row_pat_q;
        cnt_d      = cnt_q;
        key_code_d = key_code_q;
        case (state_q)
            IDLE: begin
                if (sync_row != '0) begin
                    state_d = SCAN;
                    c_d     = '0;
                end
            end
            SCAN: begin
                if (sync_row != '0) begin
                    row_pat_d = sync_row;
                    cnt_d     = '0;
                    state_d   = DEB;
                end else if (c_q == C_LAST) begin
                    state_d = IDLE;
                end else begin
                    c_d = c_q + CIDX_W'(1);
                end
            end
            DEB: begin
                if (sync_row == row_pat_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DEB_LAST) begin
                        key_code_d = deb_code;
                        state_d    = EMIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            EMIT: begin
                if (key_ready) begin
                    cnt_d   = '0;
                    state_d = REL;
                end
            end
            REL: begin
                if (sync_row == '0) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DEB_LAST) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs depend on the state register only
    always_comb begin
        col       = '1;
        key_valid = 1'b0;
        key_held  = 1'b0;
        case (state_q)
            SCAN, DEB: col       = col_onehot;
            EMIT:      key_valid = 1'b1;
            REL:       key_held  = 1'b1;
            default:   col       = '1;
        endcase
    end

    assign key_code = key_code_q;

endmodule
